// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter in front of one shared 18x18 signed
// 1.17 multiplier. One op accepted per cycle; responses come back in accept
// order exactly PIPE cycles after the accept edge, with no backpressure.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   req_valid  [NUM_REQ]      per-requester operand valid
//   req_a      [18*NUM_REQ]   multiplicand A, requester i at [18i+17:18i]
//   req_b      [18*NUM_REQ]   multiplier B, packed like req_a
//   req_ready  [NUM_REQ]      one-hot grant (combinational)
//   rsp_valid  result strobe
//   rsp_id     [5]            owner of rsp_data
//   rsp_data   [18]           signed 1.17 product
//   busy       any accepted op still waiting for its response
//
// Build option: define MULT_SAT_EN to saturate -1.0 x -1.0 to 18'h1FFFF
// instead of letting it wrap to 18'h00000.
module mult_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int PIPE    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [18*NUM_REQ-1:0]   req_a,
  input  logic [18*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [4:0]              rsp_id,
  output logic [17:0]             rsp_data,
  output logic                    busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(PIPE + 1);

  logic [PW-1:0]         ptr, gnt_idx, idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  found, accept;
  logic signed [17:0]    a_q, b_q;
  logic [PIPE:1]         vld_pipe;
  logic [PIPE:1][4:0]    id_pipe;
  logic [CW-1:0]         inflight;
  logic signed [35:0]    p_comb, p_out;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found && !reset) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= PW'(NUM_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      inflight <= '0;
    end else begin
      if (accept) begin
        ptr <= gnt_idx;
        a_q <= req_a[18*gnt_idx +: 18];
        b_q <= req_b[18*gnt_idx +: 18];
      end
      vld_pipe[1] <= accept;
      id_pipe[1]  <= accept ? 5'(gnt_idx) : 5'd0;
      for (int k = 2; k <= PIPE; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      // Simultaneous accept and response leave the count unchanged.
      case ({accept, rsp_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // The operand register is stage 1; the product then rides PIPE-1 more
  // register stages so the total depth is PIPE.
  assign p_comb = a_q * b_q;

  generate
    if (PIPE == 1) begin : g_p1
      assign p_out = p_comb;
    end else begin : g_pn
      logic signed [35:0] p_reg [PIPE-1];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < PIPE-1; k++) p_reg[k] <= '0;
        end else begin
          p_reg[0] <= p_comb;
          for (int k = 1; k < PIPE-1; k++) p_reg[k] <= p_reg[k-1];
        end
      end
      assign p_out = p_reg[PIPE-2];
    end
  endgenerate

  // p[35] != p[34] only for -1.0 x -1.0 (+1.0 is not representable).
`ifdef MULT_SAT_EN
  assign rsp_data = (p_out[35] != p_out[34]) ? 18'h1FFFF : {p_out[35], p_out[33:17]};
`else
  assign rsp_data = {p_out[35], p_out[33:17]};
`endif

  logic unused_bits;
  assign unused_bits = ^{p_out[34], p_out[16:0]};

  assign rsp_valid = vld_pipe[PIPE];
  assign rsp_id    = id_pipe[PIPE];
  assign busy      = (inflight != '0);

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb (NUM_REQ=4, PIPE=2). Table of single-requester
// vectors with constant expected products, then hand sequences for
// round-robin order, mid-operation reset and starvation. Responses are
// checked against a queue filled at handshake time.
module tb_mult_share_arb;
  localparam int NR = 4;
  localparam int PIPE = 2;
`ifdef MULT_SAT_EN
  localparam logic [17:0] NEG1SQ = 18'h1FFFF;
`else
  localparam logic [17:0] NEG1SQ = 18'h00000;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [18*NR-1:0] req_a = '0, req_b = '0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid, busy;
  logic [4:0]      rsp_id;
  logic [17:0]     rsp_data;

  mult_share_arb #(.NUM_REQ(NR), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [17:0] a, b, e; } vec_t;
  typedef struct { logic [4:0] id; logic [17:0] d; int due; } sb_t;

  vec_t        tbl[8];
  sb_t         q[$];
  logic [17:0] cur_a[NR], cur_b[NR], cur_e[NR];
  int          nvec = 0, nerr = 0, cyc = 0;
  logic        rerand = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: floor(a*b / 2^17) in 18 bits, with the lone overflow case apart.
  function automatic logic [17:0] model(input logic [17:0] a, input logic [17:0] b);
    longint p;
    if (a == 18'h20000 && b == 18'h20000) return NEG1SQ;
    p = longint'($signed(a)) * longint'($signed(b));
    return 18'(p >>> 17);
  endfunction

  function automatic void new_ops(input int i);
    cur_a[i] = 18'($urandom);
    cur_b[i] = 18'($urandom);
    cur_e[i] = model(cur_a[i], cur_b[i]);
  endfunction

  // eg: >=0 expected grant index, -1 no grant, -2 any legal grant.
  task automatic step(input logic [NR-1:0] v, input int eg, input logic rst_in);
    sb_t e;
    logic [NR-1:0] g;
    @(negedge clk);
    cyc++;
    chk("busy", busy, q.size() != 0);
    if (rsp_valid) begin
      if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_latency", cyc, e.due);
      end
    end else if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_missing", rsp_valid, 1);
    end
    reset = rst_in;
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_a[18*i +: 18] = cur_a[i];
      req_b[18*i +: 18] = cur_b[i];
    end
    if (rst_in) q.delete();
    #1;
    g = req_ready;
    if (rst_in)       chk("ready_in_reset", g, 0);
    else if (eg >= 0) chk("grant", g, NR'(1) << eg);
    else if (eg == -1) chk("grant_none", g, 0);
    else begin
      chk("grant_onehot", $onehot(g), v != 0);
      chk("grant_subset", g & ~v, 0);
    end
    for (int i = 0; i < NR; i++) begin
      if (!rst_in && g[i] && v[i]) begin
        e.id = 5'(i); e.d = cur_e[i]; e.due = cyc + PIPE;
        q.push_back(e);
        if (rerand) new_ops(i);
      end
    end
  endtask

  initial begin
    int miss;
    tbl[0] = '{0, 18'h10000, 18'h10000, 18'h08000};
    tbl[1] = '{2, 18'h20000, 18'h08000, 18'h38000};
    tbl[2] = '{1, 18'h20000, 18'h20000, NEG1SQ};
    tbl[3] = '{3, 18'h1FFFF, 18'h1FFFF, 18'h1FFFE};
    tbl[4] = '{0, 18'h3FFFF, 18'h10000, 18'h3FFFF};
    tbl[5] = '{1, 18'h20000, 18'h1FFFF, 18'h20001};
    tbl[6] = '{2, 18'h00000, 18'h2ABCD, 18'h00000};
    tbl[7] = '{3, 18'h04000, 18'h3C000, 18'h3F800};
    for (int i = 0; i < NR; i++) begin cur_a[i] = '0; cur_b[i] = '0; cur_e[i] = '0; end

    // Reset with all valids high: no grants, outputs quiet.
    step('1, -1, 1'b1);
    step('1, -1, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);

    // Single requester per vector, back to back.
    for (int t = 0; t < 8; t++) begin
      cur_a[tbl[t].id] = tbl[t].a;
      cur_b[tbl[t].id] = tbl[t].b;
      cur_e[tbl[t].id] = tbl[t].e;
      step(NR'(1) << tbl[t].id, tbl[t].id, 1'b0);
    end
    // Same requester alone for several cycles regardless of pointer.
    for (int t = 0; t < 3; t++) step(4'b0100, 2, 1'b0);
    repeat (PIPE + 2) step('0, -1, 1'b0);

    // All valid for 8 cycles after reset: strict 0,1,2,3 rotation.
    rerand = 1'b1;
    for (int i = 0; i < NR; i++) new_ops(i);
    step('0, -1, 1'b1);
    for (int t = 0; t < 8; t++) step('1, t % NR, 1'b0);
    repeat (PIPE + 2) step('0, -1, 1'b0);

    // Two accepts, then reset before the second response: it is dropped,
    // busy clears and requester 0 is granted first.
    step('1, 0, 1'b0);
    step('1, 1, 1'b0);
    step('1, -1, 1'b1);
    step('1, 0, 1'b0);
    repeat (PIPE + 2) step('0, -1, 1'b0);

    // Requester 3 steady, requester 0 toggling: 3 never waits two cycles.
    miss = 0;
    for (int t = 0; t < 16; t++) begin
      step({1'b1, 2'b00, t[0] == 1'b0}, -2, 1'b0);
      if (req_ready[3]) miss = 0; else miss++;
      chk("req3_starved", miss > 1, 0);
    end
    repeat (PIPE + 2) step('0, -1, 1'b0);
    chk("sb_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
